// File: rtl/uart_mm_slave_if.sv
// Memory-map bus between the core's map master and the UART slave.
//   HSel        : slave select / read qualifier
//   WSel        : write strobe (effective only with HSel)
//   map_Address : word index inside the UART window
//   map_Data    : write data
//   HRData      : combinational read data
interface uart_mm_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  HSel;
  logic                  WSel;
  logic [ADDR_WIDTH-1:0] map_Address;
  logic [DATA_WIDTH-1:0] map_Data;
  logic [DATA_WIDTH-1:0] HRData;

  modport master (output HSel, WSel, map_Address, map_Data, input HRData);
  modport slave  (input HSel, WSel, map_Address, map_Data, output HRData);
endinterface

// File: rtl/uart_mm_slave.sv
// Memory-mapped 8N1 UART with programmable bit period (BAUD_DIV clocks/bit).
//   clk, rst_n : system clock, async active-low reset
//   bus        : memory-map slave port (select, strobe, index, data, read data)
//   uart_tx    : serial out, idle high
//   uart_rx    : serial in, asynchronous to clk
module uart_mm_slave #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DEFAULT_BAUD_DIV = 434
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_mm_slave_if.slave  bus,
  output logic            uart_tx,
  input  logic            uart_rx
);
  localparam int unsigned DIV_W = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       tx_data_q, tx_data_d, tx_shift_q, tx_shift_d;
  logic [DIV_W-1:0] baud_q, baud_d, tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic             busy_q, busy_d, tx_q, tx_d;
  logic [7:0]       rx_data_q, rx_data_d, rx_shift_q, rx_shift_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic             rx_valid_q, rx_valid_d;
  logic [1:0]       rx_err_q, rx_err_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;

  logic wr_c, wr_txd_c, wr_ctrl_c, wr_rxv_c, wr_rxe_c, wr_baud_c;
  logic tx_last_c, rx_last_c, rx_fall_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic unused_data_bits;

  assign unused_data_bits = ^bus.map_Data[DATA_WIDTH-1:DIV_W];
  assign wr_c      = bus.HSel & bus.WSel;
  assign tx_last_c = (tx_cnt_q == tx_div_q - DIV_W'(1));
  assign rx_last_c = (rx_cnt_q == rx_div_q - DIV_W'(1));
  assign rx_fall_c = rx_prev_q & ~rx_s2_q;
  assign uart_tx   = tx_q;
  assign bus.HRData = rdata_c;

  // Write decode.
  always_comb begin
    wr_txd_c  = 1'b0;
    wr_ctrl_c = 1'b0;
    wr_rxv_c  = 1'b0;
    wr_rxe_c  = 1'b0;
    wr_baud_c = 1'b0;
    if (wr_c) begin
      case (bus.map_Address)
        ADDR_WIDTH'(0): wr_txd_c  = 1'b1;
        ADDR_WIDTH'(1): wr_ctrl_c = 1'b1;
        ADDR_WIDTH'(4): wr_rxv_c  = 1'b1;
        ADDR_WIDTH'(5): wr_rxe_c  = 1'b1;
        ADDR_WIDTH'(6): wr_baud_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Zero-latency read mux; TX_CTRL and out-of-window indices read 0.
  always_comb begin
    rdata_c = '0;
    if (bus.HSel) begin
      case (bus.map_Address)
        ADDR_WIDTH'(0): rdata_c = DATA_WIDTH'(tx_data_q);
        ADDR_WIDTH'(2): rdata_c = DATA_WIDTH'(busy_q);
        ADDR_WIDTH'(3): rdata_c = DATA_WIDTH'(rx_data_q);
        ADDR_WIDTH'(4): rdata_c = DATA_WIDTH'(rx_valid_q);
        ADDR_WIDTH'(5): rdata_c = DATA_WIDTH'(rx_err_q);
        ADDR_WIDTH'(6): rdata_c = DATA_WIDTH'(baud_q);
        default: ;
      endcase
    end
  end

  // Config registers; a divisor below 2 would break the half-bit resample.
  always_comb begin
    tx_data_d = wr_txd_c ? bus.map_Data[7:0] : tx_data_q;
    baud_d    = baud_q;
    if (wr_baud_c) begin
      baud_d = (bus.map_Data[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : bus.map_Data[DIV_W-1:0];
    end
  end

  // TX next state; the divisor is relatched at every bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_last_c ? '0 : tx_cnt_q + DIV_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_div_d   = tx_last_c ? baud_q : tx_div_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        tx_div_d = baud_q;
        if (wr_ctrl_c && bus.map_Data[0]) begin
          tx_shift_d = tx_data_q;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_last_c) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_last_c) begin
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_last_c) begin
          busy_d     = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX next state; clears are applied first so a same-edge set wins.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DIV_W'(1);
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = wr_rxv_c ? 1'b0 : rx_valid_q;
    rx_err_d   = wr_rxe_c ? 2'b00 : rx_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall_c) begin
          rx_div_d   = baud_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_last_c) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_last_c) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_err_d[1] = 1'b1;
          end else begin
            rx_err_d[0] = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State registers; the rx synchronizer resets to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_data_q  <= '0;
      baud_q     <= DIV_W'(DEFAULT_BAUD_DIV);
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(DEFAULT_BAUD_DIV);
      tx_bit_q   <= '0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      rx_data_q  <= '0;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DEFAULT_BAUD_DIV);
      rx_bit_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_data_q  <= tx_data_d;
      baud_q     <= baud_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      rx_data_q  <= rx_data_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end
endmodule

// File: tb/tb_uart_mm_slave.sv
// Directed bench for uart_mm_slave: reset, TX framing, TX-while-busy,
// RX loopback, framing/overrun/glitch handling and address decode.
module tb_uart_mm_slave;
  logic clk = 1'b0;
  logic rst_n;
  logic uart_tx;
  logic uart_rx;
  logic rx_drv;
  logic loop_en;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uart_mm_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif ();

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_mm_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEFAULT_BAUD_DIV(434)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write, consumes exactly one rising edge; returns at edge+1.
  task automatic bus_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    bif.HSel = 1'b1; bif.WSel = 1'b1;
    bif.map_Address = 32'(idx); bif.map_Data = d;
    @(posedge clk); #1;
    bif.HSel = 1'b0; bif.WSel = 1'b0;
  endtask

  // Combinational read, consumes no clock edges.
  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] d;
    bif.HSel = 1'b1; bif.WSel = 1'b0; bif.map_Address = 32'(idx);
    #1 d = bif.HRData;
    bif.HSel = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  exp_bits;
    logic [31:0] d;
    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    bif.HSel = 1'b0; bif.WSel = 1'b0; bif.map_Address = '0; bif.map_Data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset in mid-frame forces the line high without waiting for a clock.
    bus_write(6, 32'd16);
    bus_write(0, 32'h00);
    bus_write(1, 32'h1);
    repeat (40) @(posedge clk);
    #1 check("tx_low_before_reset", 32'(uart_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("tx_high_in_reset", 32'(uart_tx), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk_reg("rst_busy", 2, 32'd0);
    chk_reg("rst_baud", 6, 32'd434);
    chk_reg("rst_rxvalid", 4, 32'd0);
    chk_reg("rst_txdata", 0, 32'd0);
    chk_reg("rst_rxdata", 3, 32'd0);
    chk_reg("rst_rxerr", 5, 32'd0);

    // TX 0xA5 at 16 clocks/bit, with a data+start write landing mid-frame.
    bus_write(6, 32'd16);
    bus_write(0, 32'hA5);
    bus_write(1, 32'h1);
    chk_reg("tx_busy_set", 2, 32'd1);
    exp_bits = {1'b1, 8'hA5, 1'b0};
    repeat (8) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1 check($sformatf("tx_bit%0d", k), 32'(uart_tx), 32'(exp_bits[k]));
      if (k == 4) begin
        bus_write(0, 32'h3C);
        bus_write(1, 32'h1);
        if (k < 9) repeat (14) @(posedge clk);
      end else if (k < 9) begin
        repeat (16) @(posedge clk);
      end
    end
    repeat (7) @(posedge clk);
    #1 chk_reg("tx_busy_at_159", 2, 32'd1);
    @(posedge clk);
    #1 chk_reg("tx_busy_at_160", 2, 32'd0);
    chk_reg("tx_hold_reg", 0, 32'h3C);
    repeat (40) @(posedge clk);
    #1 check("tx_no_second_frame", 32'(uart_tx), 32'd1);
    chk_reg("tx_still_idle", 2, 32'd0);

    // Loopback 0x5A.
    loop_en = 1'b1;
    bus_write(0, 32'h5A);
    bus_write(1, 32'h1);
    repeat (190) @(posedge clk);
    #1;
    chk_reg("lb_rxdata", 3, 32'h5A);
    chk_reg("lb_rxvalid", 4, 32'd1);
    chk_reg("lb_rxerr", 5, 32'd0);
    bus_write(4, 32'd0);
    chk_reg("lb_valid_cleared", 4, 32'd0);
    loop_en = 1'b0;

    // Framing error leaves data alone.
    send_frame(8'h77, 1'b0);
    chk_reg("fe_err", 5, 32'd1);
    chk_reg("fe_data", 3, 32'h5A);
    chk_reg("fe_valid", 4, 32'd0);
    bus_write(5, 32'd0);
    chk_reg("fe_cleared", 5, 32'd0);

    // Overrun: second byte overwrites and flags.
    send_frame(8'h11, 1'b1);
    chk_reg("ov_first_valid", 4, 32'd1);
    chk_reg("ov_first_err", 5, 32'd0);
    send_frame(8'h22, 1'b1);
    chk_reg("ov_err", 5, 32'd2);
    chk_reg("ov_data", 3, 32'h22);
    chk_reg("ov_valid", 4, 32'd1);
    bus_write(4, 32'd0);
    bus_write(5, 32'd0);

    // 3-clock glitch is rejected; a following frame still decodes.
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk_reg("gl_valid", 4, 32'd0);
    chk_reg("gl_err", 5, 32'd0);
    chk_reg("gl_data", 3, 32'h22);
    send_frame(8'hC3, 1'b1);
    chk_reg("gl_next_data", 3, 32'hC3);
    chk_reg("gl_next_valid", 4, 32'd1);
    chk_reg("gl_next_err", 5, 32'd0);

    // Decode.
    bif.HSel = 1'b0; bif.map_Address = 32'd6;
    #1 d = bif.HRData;
    check("hsel0_reads_zero", d, 32'd0);
    bus_write(6, 32'd1);
    chk_reg("baud_min", 6, 32'd2);
    bus_write(7, 32'hFFFF_FFFF);
    chk_reg("idx7_read", 7, 32'd0);
    chk_reg("idx7_txdata", 0, 32'h5A);
    chk_reg("idx7_baud", 6, 32'd2);
    chk_reg("idx7_busy", 2, 32'd0);
    chk_reg("idx7_valid", 4, 32'd1);
    chk_reg("idx1_reads_zero", 1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
